// File: rtl/fft_mult_comp_pipe.sv
// Pipelined complex multiplier D*W or D*conj(W) for the FFT butterfly, with
// selectable rounding, output saturation, overflow flag and overflow counter.
module fft_mult_comp_pipe #(
   parameter int D_BIT   = 17,
   parameter int W_BIT   = 12,
   parameter int W_SHIFT = 10,
   parameter int LATENCY = 3,
   parameter int ROUND   = 1,
   parameter int CNT_BIT = 16
) (
   input  logic                      iCLK,
   input  logic                      iRESET,
   input  logic                      iVALID,
   input  logic                      iCONJ,
   input  logic signed [D_BIT-1:0]   iRE,
   input  logic signed [D_BIT-1:0]   iIM,
   input  logic signed [W_BIT-1:0]   iW_RE,
   input  logic signed [W_BIT-1:0]   iW_IM,
   input  logic                      iCLR_CNT,
   output logic                      oVALID,
   output logic signed [D_BIT-1:0]   oRE,
   output logic signed [D_BIT-1:0]   oIM,
   output logic                      oOVF,
   output logic [CNT_BIT-1:0]        oOVF_CNT
);

   localparam int PW   = D_BIT + W_BIT;
   localparam int SW   = PW + 1;
   localparam int NDLY = LATENCY - 3;
   localparam int RSH  = (W_SHIFT > 0) ? W_SHIFT - 1 : 0;
   localparam logic signed [SW-1:0] RND =
      (ROUND != 0 && W_SHIFT > 0) ? (SW'(1) << RSH) : SW'(0);

   logic                    v1, v2;
   logic                    conj1, conj2;
   logic signed [D_BIT-1:0] re1, im1;
   logic signed [W_BIT-1:0] wr1, wi1;
   logic signed [PW-1:0]    prr, pii, pir, pri;
   logic signed [SW-1:0]    sre, sim, shre, shim;
   logic [D_BIT:0]          satre, satim;

   logic                    vq  [0:NDLY];
   logic signed [D_BIT-1:0] req [0:NDLY];
   logic signed [D_BIT-1:0] imq [0:NDLY];
   logic                    ovq [0:NDLY];

   // Returns {overflow, value}: the value clamped to the D_BIT signed range.
   function automatic logic [D_BIT:0] saturate(input logic signed [SW-1:0] x);
      logic [SW-D_BIT:0] top;
      top = x[SW-1:D_BIT-1];
      if ((&top) || ~(|top))
         saturate = {1'b0, x[D_BIT-1:0]};
      else if (x[SW-1])
         saturate = {1'b1, 1'b1, {(D_BIT-1){1'b0}}};
      else
         saturate = {1'b1, 1'b0, {(D_BIT-1){1'b1}}};
   endfunction

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         v1    <= 1'b0;
         conj1 <= 1'b0;
         re1   <= '0;
         im1   <= '0;
         wr1   <= '0;
         wi1   <= '0;
      end else begin
         v1 <= iVALID;
         if (iVALID) begin
            conj1 <= iCONJ;
            re1   <= iRE;
            im1   <= iIM;
            wr1   <= iW_RE;
            wi1   <= iW_IM;
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         v2    <= 1'b0;
         conj2 <= 1'b0;
         prr   <= '0;
         pii   <= '0;
         pir   <= '0;
         pri   <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            conj2 <= conj1;
            prr   <= PW'(re1) * PW'(wr1);
            pii   <= PW'(im1) * PW'(wi1);
            pir   <= PW'(im1) * PW'(wr1);
            pri   <= PW'(re1) * PW'(wi1);
         end
      end
   end

   // Sums are one bit wider than the products so the add/subtract cannot wrap.
   always_comb begin
      sre   = conj2 ? (SW'(prr) + SW'(pii)) : (SW'(prr) - SW'(pii));
      sim   = conj2 ? (SW'(pir) - SW'(pri)) : (SW'(pir) + SW'(pri));
      shre  = (sre + RND) >>> W_SHIFT;
      shim  = (sim + RND) >>> W_SHIFT;
      satre = saturate(shre);
      satim = saturate(shim);
   end

   // Index 0 is the arithmetic result stage; higher indices are pure delay.
   always_ff @(posedge iCLK) begin
      if (iRESET) begin
         for (int k = 0; k <= NDLY; k++) begin
            vq[k]  <= 1'b0;
            req[k] <= '0;
            imq[k] <= '0;
            ovq[k] <= 1'b0;
         end
      end else begin
         vq[0] <= v2;
         if (v2) begin
            req[0] <= satre[D_BIT-1:0];
            imq[0] <= satim[D_BIT-1:0];
            ovq[0] <= satre[D_BIT] | satim[D_BIT];
         end
         for (int k = 1; k <= NDLY; k++) begin
            vq[k] <= vq[k-1];
            if (vq[k-1]) begin
               req[k] <= req[k-1];
               imq[k] <= imq[k-1];
               ovq[k] <= ovq[k-1];
            end
         end
      end
   end

   assign oVALID = vq[NDLY];
   assign oRE    = req[NDLY];
   assign oIM    = imq[NDLY];
   assign oOVF   = ovq[NDLY];

   // Clear beats a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge iCLK) begin
      if (iRESET)
         oOVF_CNT <= '0;
      else if (iCLR_CNT)
         oOVF_CNT <= '0;
      else if (oVALID && oOVF && !(&oOVF_CNT))
         oOVF_CNT <= oOVF_CNT + 1'b1;
   end

endmodule

// File: doc/fft_mult_comp_pipe.md
Name: fft_mult_comp_pipe

Overview:
Parametrised, fully pipelined complex multiplier for the FFT butterfly. It is the successor to fft_mult_comp and computes D·W or D·conj(W) on signed fixed-point data. It adds a valid pipeline, selectable rounding, output saturation with a per-sample overflow flag, a saturating overflow counter, and a configurable latency. It accepts one sample per clock with no backpressure and sits between the twiddle ROM and the butterfly adder stage.

Parameters:
D_BIT, 17, data width (signed) of iRE/iIM/oRE/oIM
W_BIT, 12, twiddle width (signed) of iW_RE/iW_IM
W_SHIFT, 10, twiddle scale: 2^W_SHIFT represents 1.0; products are shifted right by W_SHIFT; must be <= W_BIT-1
LATENCY, 3, iVALID-to-oVALID delay in clocks; legal range 3..8; stages beyond 3 are pure delay registers
ROUND, 1, 0 = truncate (arithmetic shift); 1 = round half up (add 2^(W_SHIFT-1) before shift)
CNT_BIT, 16, overflow counter width

Ports:
iCLK  in  1  clock; all logic is on the rising edge
iRESET  in  1  synchronous reset, active-high
iVALID  in  1  input sample valid
iCONJ  in  1  1 = multiply by conj(W); sampled with the data
iRE  in  D_BIT  data real part
iIM  in  D_BIT  data imaginary part
iW_RE  in  W_BIT  twiddle real part
iW_IM  in  W_BIT  twiddle imaginary part
iCLR_CNT  in  1  synchronous clear of oOVF_CNT
oVALID  out  1  output sample valid
oRE  out  D_BIT  result real part
oIM  out  D_BIT  result imaginary part
oOVF  out  1  1 = oRE or oIM was saturated for this sample; qualified by oVALID
oOVF_CNT  out  CNT_BIT  number of saturated output samples

Behaviour:
- Reset (iRESET=1 at a clock edge): valid pipeline cleared; oVALID, oRE, oIM, oOVF and oOVF_CNT are 0 on the next cycle. In-flight samples are discarded and never emerge, even if reset lasts only one cycle.
- Stage 1: register iRE, iIM, iW_RE, iW_IM and iCONJ when iVALID=1.
- Stage 2: four signed products, each D_BIT+W_BIT wide.
- Stage 3: form the sums at D_BIT+W_BIT+1 bits, then round, shift and saturate.
  - Normal: Pre = re·wr − im·wi; Pim = im·wr + re·wi.
  - iCONJ=1: Pre = re·wr + im·wi; Pim = im·wr − re·wi.
  - Each sum: add the rounding constant if ROUND=1, arithmetic shift right by W_SHIFT, then saturate to [−2^(D_BIT−1), 2^(D_BIT−1)−1].
  - oOVF = OR of the two per-component saturation events.
- Delay stages: LATENCY−3 extra register stages carry data, oOVF and valid.
- Valid gating: every data register loads only when its stage valid bit is 1. With oVALID=0, oRE, oIM and oOVF hold their last valid values. A bubble on iVALID appears exactly LATENCY cycles later on oVALID.
- Throughput: one sample per clock; back-to-back samples need no idle cycles; iCONJ may change every sample.
- Counter: increments on a cycle where oVALID=1 and oOVF=1. It sticks at all-ones and does not wrap. iCLR_CNT=1 sets it to 0 next cycle and wins over a simultaneous increment. iRESET has priority over everything.
- No internal state other than the pipeline and the counter; there is no FSM beyond the valid shift chain.

Test Plan (defaults D_BIT=17, W_BIT=12, W_SHIFT=10, LATENCY=3, ROUND=1):
- Identity: D=(16384,0), W=(1024,0), iVALID one cycle -> oVALID exactly 3 cycles later; out (16384,0); oOVF=0.
- 90° rotation and conjugate: D=(16384,8192), W=(0,1024).
  - iCONJ=0 -> (−8192,16384).
  - Next cycle, same data with iCONJ=1 -> (8192,−16384).
  - Both outputs arrive on consecutive cycles.
- Saturation:
  - D=(−65536,0), W=(−1024,0) -> (65535,0), oOVF=1.
  - D=(−65536,−65536), W=(1024,−1024) -> (−65536,0), oOVF=1.
  - oOVF_CNT=2 afterwards.
  - iCLR_CNT asserted in the same cycle as a third overflowing oVALID -> oOVF_CNT=0.
- Rounding: D=(3,0), W=(512,0) -> oRE=2 (ROUND=1), oRE=1 (ROUND=0). D=(−3,0), same W -> oRE=−1 (ROUND=1), oRE=−2 (ROUND=0).
- Streaming and bubbles: 8 samples with iVALID pattern 1,1,0,1,1,1,0,1 and random unit-magnitude D/W -> oVALID shows the same pattern shifted 3 cycles; each result matches the reference model within ±1 LSB; outputs hold during bubbles. Repeat with LATENCY=5 -> 5-cycle shift.
- Reset mid-stream: iRESET=1 for one cycle while 3 samples are in flight -> none emerge; oVALID, oRE, oIM, oOVF and oOVF_CNT are 0; the next sample after reset has normal latency.
